// File: rtl/tick_step_controller.sv
// Run/pause/single-step controller: debounced buttons drive a PAUSE/RUN/STEP FSM
// that gates a programmable tick divider and counts issued ticks.
module tick_step_controller #(
  parameter int unsigned DivBits        = 16,
  parameter int unsigned DebounceCycles = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [DivBits-1:0] Divisor,
  input  logic               RunBtn,
  input  logic               StepBtn,
  input  logic               Halt,
  output logic               Tick,
  output logic               Running,
  output logic [31:0]        TickCount
);

  localparam int unsigned DbW = (DebounceCycles < 2) ? 1 : $clog2(DebounceCycles);
  localparam logic [DbW-1:0] DbLast = DbW'(DebounceCycles - 1);

  typedef enum logic [1:0] {PAUSE, RUN, STEP} state_t;

  // Index 0 = run button, index 1 = step button.
  logic [1:0]     btn_raw;
  logic [1:0]     sync1;
  logic [1:0]     sync2;
  logic [1:0]     deb;
  logic [1:0]     deb_q;
  logic [DbW-1:0] db_cnt [2];
  logic [1:0]     press;

  state_t             state;
  logic [DivBits-1:0] div_cnt;
  logic               tick_q;
  logic               running_q;
  logic [31:0]        tick_count_q;

  assign btn_raw = {StepBtn, RunBtn};

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int unsigned i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      deb_q <= deb;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] != deb[i]) begin
          if (db_cnt[i] == DbLast) begin
            deb[i]    <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DbW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // Press is high for the first cycle the debounced level reads 1.
  assign press = deb & ~deb_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state        <= PAUSE;
      div_cnt      <= '0;
      tick_q       <= 1'b0;
      running_q    <= 1'b0;
      tick_count_q <= '0;
    end else begin
      tick_q       <= 1'b0;
      div_cnt      <= '0;
      tick_count_q <= tick_count_q + 32'(tick_q);
      case (state)
        PAUSE: begin
          if (!Halt) begin
            if (press[0]) begin
              state     <= RUN;
              running_q <= 1'b1;
            end else if (press[1]) begin
              state  <= STEP;
              tick_q <= 1'b1;
            end
          end
        end
        RUN: begin
          // The tick decision stands even when leaving RUN this cycle.
          if (div_cnt >= Divisor) begin
            tick_q <= 1'b1;
          end else begin
            div_cnt <= div_cnt + DivBits'(1);
          end
          if (Halt || press[0]) begin
            state     <= PAUSE;
            running_q <= 1'b0;
            div_cnt   <= '0;
          end
        end
        STEP: begin
          state <= PAUSE;
        end
        default: begin
          state     <= PAUSE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign Tick      = tick_q;
  assign Running   = running_q;
  assign TickCount = tick_count_q;

endmodule

// File: doc/tick_step_controller.md
TICK_STEP_CONTROLLER -- requirements
Module: tick_step_controller

Interface
REQ-001 SHALL have parameter DivBits, default 16, width of the divider counter and Divisor.
REQ-002 SHALL have parameter DebounceCycles, default 4, consecutive stable cycles required to accept a button level.
REQ-003 SHALL have port Clock  in  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port Divisor  in  DivBits  tick period minus one, in Clock cycles.
REQ-006 SHALL have port RunBtn  in  1  raw asynchronous run/pause toggle button.
REQ-007 SHALL have port StepBtn  in  1  raw asynchronous single-step button.
REQ-008 SHALL have port Halt  in  1  synchronous halt request from the datapath.
REQ-009 SHALL have port Tick  out  1  registered one-cycle enable pulse, fanned out to register Tick inputs.
REQ-010 SHALL have port Running  out  1  high while in state RUN.
REQ-011 SHALL have port TickCount  out  32  count of Tick pulses issued since reset.

Function
REQ-012 SHALL pass RunBtn and StepBtn each through a two-flop synchronizer.
REQ-013 SHALL accept a new debounced level only after the synchronized input differs from the current debounced level for DebounceCycles consecutive cycles; any bounce restarts the count.
REQ-014 SHALL generate a one-cycle press pulse in the cycle after a debounced level changes 0->1; 1->0 changes generate nothing.
REQ-015 SHALL implement states PAUSE, RUN and STEP; reset state PAUSE.
REQ-016 PAUSE: Halt high -> stay in PAUSE; else run press -> RUN; else step press -> STEP; simultaneous run and step press -> RUN.
REQ-017 RUN: Halt high or run press -> PAUSE; step press ignored.
REQ-018 STEP: Tick high for exactly one cycle, then unconditionally -> PAUSE; presses during STEP are ignored.
REQ-019 Divider counter SHALL be cleared to 0 on every entry to RUN and held at 0 outside RUN.
REQ-020 In RUN, when counter >= Divisor, Tick SHALL be high the next cycle and counter SHALL return to 0; otherwise counter increments by 1.
REQ-021 Divisor = 0 SHALL give Tick every cycle in RUN; Divisor lowered below the current count SHALL give a Tick on the next cycle (>= rule).
REQ-022 First Tick after entering RUN SHALL occur Divisor+1 cycles after the entry cycle.
REQ-023 Tick SHALL never be high in PAUSE except for the one cycle after a RUN->PAUSE transition whose last RUN cycle met the REQ-020 condition.
REQ-024 TickCount SHALL increment by 1 in each cycle Tick is high and wrap from 0xFFFFFFFF to 0.
REQ-025 Running SHALL be registered and equal (state == RUN).

Reset
REQ-026 Reset high SHALL immediately force state PAUSE, Tick 0, Running 0, TickCount 0, divider counter 0, debounce counters 0, debounced levels 0, synchronizer flops 0.
REQ-027 Reset asserted mid-RUN or mid-STEP SHALL suppress any pending Tick; after release, the block SHALL stay in PAUSE until a new press is accepted.
REQ-028 A button held high through reset release SHALL produce a press pulse after synchronizer plus DebounceCycles latency.

Verification
REQ-029 DebounceCycles=4, Divisor=3: clean RunBtn press -> Running 1, then Tick every 4 cycles; TickCount 5 after 20 cycles in RUN.
REQ-030 RunBtn bounce 1,0,1,0 one cycle each then steady 1 -> exactly one press, one entry to RUN.
REQ-031 PAUSE, StepBtn press -> exactly one Tick pulse, TickCount +1, Running stays 0.
REQ-032 RUN, Divisor=0 -> Tick high every cycle; Halt pulse -> Running 0 next cycle, Tick stops.
REQ-033 RUN with Divisor=100, counter at 50, Divisor changed to 10 -> Tick on next cycle, then every 11 cycles.
REQ-034 TickCount preloaded via forced RUN to 0xFFFFFFFF, one more Tick -> TickCount 0; Reset mid-RUN -> all outputs 0 the same cycle.
